// File: rtl/seq_mult16_pkg.sv
// Shared constants and state encoding for the sequential 16x16 multiplier.
package seq_mult16_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int MUL_W     = 16;
  localparam int PROD_W    = 32;
  localparam int ITER_LAST = 15;

endpackage

// File: rtl/seq_mult16_if.sv
// Start/busy/done handshake and operand/product bus of the multiplier.
interface seq_mult16_if;

  logic                                 start;
  logic [seq_mult16_pkg::MUL_W-1:0]     a;
  logic [seq_mult16_pkg::MUL_W-1:0]     b;
  logic                                 busy;
  logic                                 done;
  logic [seq_mult16_pkg::PROD_W-1:0]    product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);

endinterface

// File: rtl/seq_mult16_cla.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a second lookahead level.
module seq_mult16_cla (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        pout,
  output logic        gout
);

  logic [15:0] p, g, c;
  logic [3:0]  gp, gg;
  logic [4:0]  gc;

  always_comb begin
    p  = a ^ b;
    g  = a & b;
    gp = '0;
    gg = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (&p[4*k+2 +: 2] & g[4*k+1])
            | (&p[4*k+1 +: 3] & g[4*k]);
    end

    gout  = gg[3] | (gp[3] & gg[2]) | (&gp[3:2] & gg[1]) | (&gp[3:1] & gg[0]);
    pout  = &gp;
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (&gp[1:0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (&gp[2:1] & gg[0]) | (&gp[2:0] & cin);
    gc[4] = gout | (pout & cin);

    c = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int unsigned j = 1; j < 4; j++)
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
    end

    sum  = p ^ c;
    cout = gc[4];
  end

endmodule

// File: rtl/seq_mult16.sv
// Unsigned shift-and-add multiplier: one partial product per clock, fixed 16-cycle latency.
module seq_mult16
  import seq_mult16_pkg::*;
#(
  parameter int WIDTH = MUL_W,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  seq_mult16_if.slave     bus
);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, acc_hi, acc_lo;
  logic [CNT_W-1:0]   count;
  logic               busy_r, done_r;
  logic [2*WIDTH-1:0] product_r;
  logic               load, step, last;

  logic [WIDTH-1:0]   addend, sum;
  logic               cout;

  assign addend = acc_lo[0] ? mcand : '0;

  seq_mult16_cla u_cla (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout),
    .pout (),
    .gout ()
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (count == CNT_W'(ITER_LAST)) begin
          last      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The shift keeps the adder carry as the new MSB, so the accumulator is effectively 33 bits wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      count     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
    end else begin
      state  <= state_nxt;
      done_r <= last;
      if (load) begin
        mcand  <= bus.a;
        acc_lo <= bus.b;
        acc_hi <= '0;
        count  <= '0;
        busy_r <= 1'b1;
      end
      if (step) begin
        acc_hi <= {cout, sum[WIDTH-1:1]};
        acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
        count  <= count + 1'b1;
        if (last) begin
          product_r <= {cout, sum, acc_lo[WIDTH-1:1]};
          busy_r    <= 1'b0;
        end
      end
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: doc/seq_mult16.md
Name: seq_mult16

Overview:
- Unsigned 16x16 shift-and-add multiplier, one partial product per clock.
- Sits downstream of the 16-bit lookahead adder: it instantiates that adder and consumes its sum/carry every iteration.
- Produces a 32-bit product through a start/busy/done handshake.
- Datapath for the lab CPU's MUL instruction.

Parameters:
- WIDTH, 16, operand width. Must equal the adder width. Only 16 is supported.
- CNT_W, 5, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to multiply. Sampled only in IDLE.
- a  input  16  multiplicand. Captured on the accepting edge.
- b  input  16  multiplier. Captured on the accepting edge.
- busy  output  1  high while an operation is in progress (RUN).
- done  output  1  one-cycle pulse when the product is valid.
- product  output  32  result. Held until the next accepted start completes.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - state=IDLE, busy=0, done=0, product=0.
  - Internal registers (mcand, acc_hi, acc_lo, carry, count) are all 0.
- States: IDLE, RUN. The FSM has no separate DONE state; done is a registered flag.
- IDLE with start=1 at edge T0:
  - mcand<=a, acc_lo<=b, acc_hi<=0, count<=0.
  - state<=RUN, busy<=1.
- IDLE with start=0: hold all registers.
- Each RUN edge T1..T16 performs one iteration:
  - Adder inputs are acc_hi and (acc_lo[0] ? mcand : 16'h0), with cin=0.
  - {acc_hi, acc_lo} <= {cout, sum, acc_lo[15:1]}, i.e. a 33-bit right shift. The adder carry is never dropped.
  - count<=count+1.
- At edge T16 (count==15 during the step):
  - product <= the post-shift {acc_hi, acc_lo}.
  - done<=1, busy<=0, state<=IDLE.
- Latency is fixed: 16 cycles from the accepting edge to done high. There is no early termination for zero operands.
- done is high for exactly one cycle and clears at the next edge.
- product remains stable until the next product load (edge T16 of a later operation).
- start while RUN (including at edge T16) is ignored. It is neither queued nor does it restart the operation.
- start in the cycle where done=1 is accepted, because state is already IDLE. Back-to-back operations therefore run at 17 cycles each.
- a/b changes during RUN have no effect.
- Reset asserted mid-operation:
  - Aborts immediately; all outputs go to their reset values.
  - No done pulse is produced for the aborted operation.
  - After release, the block waits in IDLE.
- Arithmetic is unsigned only. 0xFFFF*0xFFFF = 0xFFFE0001 must be exact, which requires the carry path.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=1'b0, ST_RUN=1'b1;
  - MUL_W=16, PROD_W=32, ITER_LAST=15.
- One sub-module: the existing 16-bit carry-lookahead adder, instantiated once with cin tied to 0 and pout/gout left unconnected.
- Everything else (FSM, counter, shift register) stays in seq_mult16.

Test Plan:
- Reset, then a=7, b=3, start pulse for 1 cycle -> busy high for 16 cycles; done pulses once; product=32'h00000015. product stays 0x15 for the following 20 idle cycles.
- a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001 after exactly 16 cycles. This covers the adder carry-out path.
- a=0, b=16'h1234 and a=16'h1234, b=0 -> product=0. done still occurs at cycle 16 in both cases (fixed latency).
- Start a=5, b=6. At cycle 5, pulse start with a=9, b=9 -> the second start is ignored; product=30 (0x1E); only one done pulse.
- Start a=100, b=200. Assert rst at cycle 8 for 2 cycles -> busy, done and product go to 0 immediately on assertion; no done pulse follows. Then start a=100, b=200 again -> product=20000 (0x4E20).
- Start a=2, b=3. Hold start=1 continuously with a=4, b=5 after the first edge -> first done gives product=6. A new op is accepted in the done cycle; the second done comes 17 cycles after the first with product=20.
